picosoc_iomem_timer: RTL and testbench

Memory-mapped peripheral on the PicoSoC iomem bus, downstream of `picosoc` in place of the bench-level inline GPIO register. It decodes the `0x03xxxxxx` window and provides a 32-bit GPIO output register and a synchronised GPIO input. It also provides a 32-bit prescaled down-counter timer with auto-reload and a level interrupt. The bus behaviour is identical to the existing GPIO slave: a one-cycle `iomem_ready` pulse with byte-strobed writes.

---
 rtl/picosoc_iomem_timer.sv | 198 +++++++++++++++++++
 tb/tb_picosoc_iomem_timer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picosoc_iomem_timer.sv
// picosoc_iomem_timer
// -------------------
// PicoSoC iomem slave for the BASE_ADDR<<24 window. It provides a GPIO output
// register, a two-flop synchronised GPIO input, and a prescaled 32-bit
// down-counter timer. The timer has auto-reload and a level interrupt.
//
// Register map (byte offset, selected by iomem_addr[4:2]):
//   0x00 GPIO_OUT rw    0x04 GPIO_IN ro    0x08 CTRL rw    0x0C COUNT rw
//   0x10 RELOAD rw      0x14 STATUS (bit0 EXPIRED, write-1-to-clear)
//   0x18/0x1C unmapped: read 0, writes ignored, still acknowledged
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   iomem_valid  bus request, held by the master until iomem_ready
//   iomem_ready  registered one-cycle acknowledge
//   iomem_wstrb  byte write strobes (0 = read)
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  registered read data (pre-write value on writes)
//   gpio_out     GPIO output register
//   gpio_in      asynchronous GPIO inputs
//   irq          timer interrupt, EXPIRED & IRQEN, registered
module picosoc_iomem_timer #(
    parameter logic [7:0] BASE_ADDR = 8'h03
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [31:0] gpio_out,
    input  logic [31:0] gpio_in,
    output logic        irq
);

    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] gpioOut_q, gpioOut_d;
    logic [31:0] sync1_q, sync1_d;
    logic [31:0] sync2_q, sync2_d;
    logic        en_q, en_d;
    logic        autoReload_q, autoReload_d;
    logic        irqEn_q, irqEn_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pre_q, pre_d;
    logic [31:0] count_q, count_d;
    logic [31:0] reload_q, reload_d;
    logic        expired_q, expired_d;
    logic        irq_q, irq_d;

    logic        sel;
    logic        wrEn;
    logic [2:0]  regIdx;
    logic [31:0] readMux;
    logic        tick;
    logic        expire;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^{iomem_addr[23:5], iomem_addr[1:0]};

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
        end
        return res;
    endfunction

    assign sel    = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
    assign wrEn   = sel && (iomem_wstrb != 4'b0000);
    assign regIdx = iomem_addr[4:2];
    assign tick   = en_q && (pre_q == prescale_q);
    assign expire = tick && (count_q == 32'd0);

    always_comb begin
        readMux = 32'd0;
        case (regIdx)
            3'd0:    readMux = gpioOut_q;
            3'd1:    readMux = sync2_q;
            3'd2:    readMux = {prescale_q, 13'd0, irqEn_q, autoReload_q, en_q};
            3'd3:    readMux = count_q;
            3'd4:    readMux = reload_q;
            3'd5:    readMux = {31'd0, expired_q};
            default: readMux = 32'd0;
        endcase
    end

    // Timer update first, then bus writes, so a bus write overrides the
    // timer for the register it targets. The exception is STATUS: an expiry
    // on the same edge as a clear keeps EXPIRED set.
    always_comb begin
        ready_d      = sel;
        rdata_d      = sel ? readMux : rdata_q;
        gpioOut_d    = gpioOut_q;
        sync1_d      = gpio_in;
        sync2_d      = sync1_q;
        en_d         = en_q;
        autoReload_d = autoReload_q;
        irqEn_d      = irqEn_q;
        prescale_d   = prescale_q;
        pre_d        = pre_q;
        count_d      = count_q;
        reload_d     = reload_q;
        expired_d    = expired_q;
        irq_d        = expired_q & irqEn_q;

        if (!en_q || tick) begin
            pre_d = 16'd0;
        end else begin
            pre_d = pre_q + 16'd1;
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expired_d = 1'b1;
                if (autoReload_q) begin
                    count_d = reload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (wrEn) begin
            case (regIdx)
                3'd0: gpioOut_d = mergeBytes(gpioOut_q, iomem_wdata, iomem_wstrb);
                3'd2: begin
                    if (iomem_wstrb[0]) begin
                        en_d         = iomem_wdata[0];
                        autoReload_d = iomem_wdata[1];
                        irqEn_d      = iomem_wdata[2];
                        // Disabling parks the prescaler so a later enable
                        // starts a full PRESCALE+1 period.
                        if (!iomem_wdata[0]) pre_d = 16'd0;
                    end
                    if (iomem_wstrb[2]) prescale_d[7:0]  = iomem_wdata[23:16];
                    if (iomem_wstrb[3]) prescale_d[15:8] = iomem_wdata[31:24];
                end
                3'd3: count_d  = mergeBytes(count_q, iomem_wdata, iomem_wstrb);
                3'd4: reload_d = mergeBytes(reload_q, iomem_wdata, iomem_wstrb);
                3'd5: begin
                    if (iomem_wstrb[0] && iomem_wdata[0] && !expire) expired_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q      <= 1'b0;
            rdata_q      <= 32'd0;
            gpioOut_q    <= 32'd0;
            sync1_q      <= 32'd0;
            sync2_q      <= 32'd0;
            en_q         <= 1'b0;
            autoReload_q <= 1'b0;
            irqEn_q      <= 1'b0;
            prescale_q   <= 16'd0;
            pre_q        <= 16'd0;
            count_q      <= 32'd0;
            reload_q     <= 32'd0;
            expired_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            gpioOut_q    <= gpioOut_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            en_q         <= en_d;
            autoReload_q <= autoReload_d;
            irqEn_q      <= irqEn_d;
            prescale_q   <= prescale_d;
            pre_q        <= pre_d;
            count_q      <= count_d;
            reload_q     <= reload_d;
            expired_q    <= expired_d;
            irq_q        <= irq_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign gpio_out    = gpioOut_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_picosoc_iomem_timer.sv
// tb_picosoc_iomem_timer
// ----------------------
// Directed and randomised bench for picosoc_iomem_timer. Inputs are driven and
// outputs sampled on the falling edge. Every bus transaction takes exactly two
// cycles, so accept edges are spaced predictably. The timer reference model
// counts ticks as (edges since enable)/(PRESCALE+1) and then applies the
// decrement/expire/reload rules tick by tick.
module tb_picosoc_iomem_timer;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in;
    logic        irq;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    picosoc_iomem_timer #(.BASE_ADDR(8'h03)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .gpio_out    (gpio_out),
        .gpio_in     (gpio_in),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after posedge N, cyc reads N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request at a falling edge. Check the ready pulse and its drop,
    // return read data and the number of the accepting edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] strb,
                                 input logic [31:0] data, output logic [31:0] rd,
                                 output int acc);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = data;
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        checkOutput("ready_pulse", {31'd0, iomem_ready}, 32'd1);
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        @(negedge clk);
        checkOutput("ready_single", {31'd0, iomem_ready}, 32'd0);
    endtask

    function automatic logic [31:0] mergeModel(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Timer state after nTicks prescaler ticks from an enable with count c0.
    task automatic timerModel(input int c0, input int rl, input bit ar, input int nTicks,
                              output int cnt, output bit ex, output bit en);
        cnt = c0;
        ex  = 1'b0;
        en  = 1'b1;
        for (int j = 0; j < nTicks && en; j++) begin
            if (cnt != 0) cnt--;
            else begin
                ex = 1'b1;
                if (ar) cnt = rl;
                else en = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] rdv;
        logic [31:0] gpioModel;
        logic [31:0] dat;
        logic [3:0]  strb;
        int          acc;
        int          w;
        int          cnt;
        bit          ex;
        bit          en;
        bit          sawReady;

        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        iomem_addr  = 32'd0;
        iomem_wdata = 32'd0;
        gpio_in     = 32'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Reset state
        checkOutput("rst_ready", {31'd0, iomem_ready}, 32'd0);
        checkOutput("rst_rdata", iomem_rdata, 32'd0);
        checkOutput("rst_gpio_out", gpio_out, 32'd0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);

        // GPIO byte lanes
        applyStimulus(BASE + 32'h00, 4'hF, 32'hA5A5_A5A5, rdv, acc);
        applyStimulus(BASE + 32'h00, 4'h1, 32'h0000_003C, rdv, acc);
        checkOutput("gpio_wr_old", rdv, 32'hA5A5_A5A5);
        checkOutput("gpio_lane", gpio_out, 32'hA5A5_A53C);
        applyStimulus(BASE + 32'h00, 4'h0, 32'hFFFF_FFFF, rdv, acc);
        checkOutput("gpio_rd", rdv, 32'hA5A5_A53C);

        // Random byte-lane writes and reads of GPIO_OUT
        gpioModel = 32'hA5A5_A53C;
        for (int i = 0; i < 8; i++) begin
            dat  = $urandom;
            strb = 4'($urandom_range(0, 15));
            applyStimulus(BASE + 32'h00, strb, dat, rdv, acc);
            checkOutput("gpio_rand_old", rdv, gpioModel);
            gpioModel = mergeModel(gpioModel, dat, strb);
            checkOutput("gpio_rand_out", gpio_out, gpioModel);
        end

        // GPIO_IN through the synchroniser
        for (int i = 0; i < 4; i++) begin
            dat = $urandom;
            gpio_in = dat;
            repeat (2) @(negedge clk);
            applyStimulus(BASE + 32'h04, 4'h0, 32'd0, rdv, acc);
            checkOutput("gpio_in", rdv, dat);
        end

        // One-shot, PRESCALE=0
        applyStimulus(BASE + 32'h10, 4'hF, 32'd0, rdv, acc);
        applyStimulus(BASE + 32'h0C, 4'hF, 32'd3, rdv, acc);
        applyStimulus(BASE + 32'h08, 4'hF, 32'h0000_0005, rdv, acc);
        applyStimulus(BASE + 32'h0C, 4'h0, 32'd0, rdv, acc);
        checkOutput("oneshot_cnt2", rdv, 32'd2);
        applyStimulus(BASE + 32'h0C, 4'h0, 32'd0, rdv, acc);
        checkOutput("oneshot_cnt0", rdv, 32'd0);
        applyStimulus(BASE + 32'h14, 4'h0, 32'd0, rdv, acc);
        checkOutput("oneshot_expired", rdv, 32'd1);
        checkOutput("oneshot_irq", {31'd0, irq}, 32'd1);
        applyStimulus(BASE + 32'h08, 4'h0, 32'd0, rdv, acc);
        checkOutput("oneshot_ctrl", rdv, 32'h0000_0004);
        applyStimulus(BASE + 32'h14, 4'hF, 32'd0, rdv, acc);
        applyStimulus(BASE + 32'h14, 4'h0, 32'd0, rdv, acc);
        checkOutput("status_w0_keep", rdv, 32'd1);
        applyStimulus(BASE + 32'h14, 4'hF, 32'd1, rdv, acc);
        checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
        applyStimulus(BASE + 32'h14, 4'h0, 32'd0, rdv, acc);
        checkOutput("status_cleared", rdv, 32'd0);

        // Auto-reload, PRESCALE=3, IRQEN=0
        applyStimulus(BASE + 32'h10, 4'hF, 32'd2, rdv, acc);
        applyStimulus(BASE + 32'h0C, 4'hF, 32'd0, rdv, acc);
        applyStimulus(BASE + 32'h08, 4'hF, 32'h0003_0003, rdv, acc);
        repeat (4) @(negedge clk);
        applyStimulus(BASE + 32'h0C, 4'h0, 32'd0, rdv, acc);
        checkOutput("ar_cnt_a", rdv, 32'd2);
        applyStimulus(BASE + 32'h0C, 4'h0, 32'd0, rdv, acc);
        checkOutput("ar_cnt_b", rdv, 32'd2);
        applyStimulus(BASE + 32'h0C, 4'h0, 32'd0, rdv, acc);
        checkOutput("ar_cnt_c", rdv, 32'd1);
        applyStimulus(BASE + 32'h14, 4'h0, 32'd0, rdv, acc);
        checkOutput("ar_expired", rdv, 32'd1);
        checkOutput("ar_irq_off", {31'd0, irq}, 32'd0);
        applyStimulus(BASE + 32'h08, 4'hF, 32'd0, rdv, acc);
        applyStimulus(BASE + 32'h14, 4'hF, 32'd1, rdv, acc);

        // Collision: STATUS clear on the expiry edge (PRESCALE=1 puts the
        // first tick exactly on the next accept edge)
        applyStimulus(BASE + 32'h0C, 4'hF, 32'd0, rdv, acc);
        applyStimulus(BASE + 32'h08, 4'hF, 32'h0001_0005, rdv, acc);
        applyStimulus(BASE + 32'h14, 4'hF, 32'd1, rdv, acc);
        checkOutput("coll_status_old", rdv, 32'd0);
        applyStimulus(BASE + 32'h14, 4'h0, 32'd0, rdv, acc);
        checkOutput("coll_status_set_wins", rdv, 32'd1);
        applyStimulus(BASE + 32'h08, 4'hF, 32'd0, rdv, acc);
        applyStimulus(BASE + 32'h14, 4'hF, 32'd1, rdv, acc);

        // Collision: COUNT write on a tick edge
        applyStimulus(BASE + 32'h0C, 4'hF, 32'd5, rdv, acc);
        applyStimulus(BASE + 32'h08, 4'hF, 32'h0001_0003, rdv, acc);
        applyStimulus(BASE + 32'h0C, 4'hF, 32'd7, rdv, acc);
        checkOutput("coll_count_old", rdv, 32'd5);
        applyStimulus(BASE + 32'h0C, 4'h0, 32'd0, rdv, acc);
        checkOutput("coll_count_bus_wins", rdv, 32'd7);

        // Randomised timer runs against the tick-count model
        for (int i = 0; i < 10; i++) begin
            int c0, rl, p, d;
            bit ar, ie;
            c0 = $urandom_range(0, 6);
            rl = $urandom_range(0, 5);
            p  = $urandom_range(0, 3);
            d  = $urandom_range(0, 20);
            ar = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            applyStimulus(BASE + 32'h08, 4'hF, 32'd0, rdv, acc);
            applyStimulus(BASE + 32'h14, 4'hF, 32'd1, rdv, acc);
            applyStimulus(BASE + 32'h10, 4'hF, 32'(rl), rdv, acc);
            applyStimulus(BASE + 32'h0C, 4'hF, 32'(c0), rdv, acc);
            applyStimulus(BASE + 32'h08, 4'hF, {16'(p), 13'd0, ie, ar, 1'b1}, rdv, w);
            repeat (d) @(negedge clk);
            applyStimulus(BASE + 32'h0C, 4'h0, 32'd0, rdv, acc);
            timerModel(c0, rl, ar, (acc - 1 - w) / (p + 1), cnt, ex, en);
            checkOutput("rand_count", rdv, 32'(cnt));
            applyStimulus(BASE + 32'h14, 4'h0, 32'd0, rdv, acc);
            timerModel(c0, rl, ar, (acc - 1 - w) / (p + 1), cnt, ex, en);
            checkOutput("rand_expired", rdv, {31'd0, ex});
            applyStimulus(BASE + 32'h08, 4'h0, 32'd0, rdv, acc);
            timerModel(c0, rl, ar, (acc - 1 - w) / (p + 1), cnt, ex, en);
            checkOutput("rand_ctrl", rdv, {16'(p), 13'd0, ie, ar, en});
            timerModel(c0, rl, ar, (cyc - 1 - w) / (p + 1), cnt, ex, en);
            checkOutput("rand_irq", {31'd0, irq}, {31'd0, ex & ie});
        end
        applyStimulus(BASE + 32'h08, 4'hF, 32'd0, rdv, acc);
        applyStimulus(BASE + 32'h14, 4'hF, 32'd1, rdv, acc);

        // Decode: outside window is ignored, unmapped offsets read 0
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0200_0000;
        iomem_wstrb = 4'hF;
        iomem_wdata = ~gpioModel;
        sawReady    = 1'b0;
        repeat (10) begin
            @(negedge clk);
            sawReady = sawReady | iomem_ready;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        checkOutput("decode_no_ready", {31'd0, sawReady}, 32'd0);
        checkOutput("decode_no_write", gpio_out, gpioModel);
        applyStimulus(BASE + 32'h18, 4'hF, 32'hDEAD_BEEF, rdv, acc);
        applyStimulus(BASE + 32'h18, 4'h0, 32'd0, rdv, acc);
        checkOutput("unmapped_18", rdv, 32'd0);
        applyStimulus(BASE + 32'h1C, 4'h0, 32'd0, rdv, acc);
        checkOutput("unmapped_1c", rdv, 32'd0);
        checkOutput("unmapped_no_write", gpio_out, gpioModel);

        // Reset mid-count
        applyStimulus(BASE + 32'h00, 4'hF, 32'h1234_5678, rdv, acc);
        applyStimulus(BASE + 32'h0C, 4'hF, 32'd100, rdv, acc);
        applyStimulus(BASE + 32'h08, 4'hF, 32'h0000_0005, rdv, acc);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checkOutput("midrst_gpio_out", gpio_out, 32'd0);
        checkOutput("midrst_ready", {31'd0, iomem_ready}, 32'd0);
        checkOutput("midrst_rdata", iomem_rdata, 32'd0);
        checkOutput("midrst_irq", {31'd0, irq}, 32'd0);
        repeat (5) @(negedge clk);
        applyStimulus(BASE + 32'h0C, 4'h0, 32'd0, rdv, acc);
        checkOutput("midrst_count", rdv, 32'd0);
        applyStimulus(BASE + 32'h08, 4'h0, 32'd0, rdv, acc);
        checkOutput("midrst_ctrl", rdv, 32'd0);
        applyStimulus(BASE + 32'h10, 4'h0, 32'd0, rdv, acc);
        checkOutput("midrst_reload", rdv, 32'd0);
        applyStimulus(BASE + 32'h14, 4'h0, 32'd0, rdv, acc);
        checkOutput("midrst_status", rdv, 32'd0);
        checkOutput("midrst_irq_late", {31'd0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
